mm_dot_ctrl: RTL and testbench
==============================

# mm_dot_ctrl

Sequencer for one MM `MAC` lane. It computes a single dot product of length `len` by streaming operand pairs from two single-port read buffers into the MAC, clearing the accumulator first and draining the pipeline afterwards. It captures the final accumulator value and reports completion with a start/busy/done handshake. It sits between the MM tile scheduler, which issues commands, and the MAC datapath.

## Interface
- `ADDR_W`, default 8: buffer address width.
- `LEN_W`, default 9: vector length width; `len` ranges 0..2^LEN_W-1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: command request, sampled only in IDLE.
- `abort` in 1: synchronous abort of the running command.
- `len` in LEN_W: element count, latched on accept.
- `base_a` in ADDR_W: data buffer start address, latched on accept.
- `base_b` in ADDR_W: weight buffer start address, latched on accept.
- `stride_b` in ADDR_W: weight address increment, latched on accept.
- `stall` in 1: back-pressure from the buffers; suppresses issue while high.
- `rd_en` out 1: read strobe, common to both buffers.
- `rd_addr_a` out ADDR_W: data buffer read address.
- `rd_addr_b` out ADDR_W: weight buffer read address.
- `rdata_a` in 32: data read word, valid the cycle after `rd_en`.
- `rdata_b` in 32: weight read word, valid the cycle after `rd_en`.
- `mac_clear` out 1: drives MAC `clear`.
- `mac_data` out Scalar: drives MAC `data`.
- `mac_weight` out Scalar: drives MAC `weight`.
- `mac_out` in 32: MAC accumulator output, IEEE single.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle completion pulse.
- `result` out 32: captured dot product; holds until the next capture.

## Operation
- FSM states: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `len`, `base_a`, `base_b` and `stride_b`, sets `idx`=0 and moves to CLEAR.
  - `start` in any other state is ignored (no queueing).
- CLEAR:
  - `mac_clear`=1 for exactly one cycle.
  - Next state is ISSUE if `len`≠0, otherwise DRAIN.
- ISSUE, each cycle with `stall`=0:
  - `rd_en`=1.
  - `rd_addr_a`=`base_a`+`idx`.
  - `rd_addr_b`=`base_b`+`idx`·`stride_b`, kept as a running sum: add `stride_b` per issue, no multiplier.
  - `idx` increments.
  - After the issue with `idx`=`len`-1, go to DRAIN.
- ISSUE, cycle with `stall`=1: `rd_en`=0, and `idx` and both addresses hold.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Operand path:
  - `rd_v` is `rd_en` registered.
  - `mac_data` = {value=`rdata_a`, valid=`rd_v`}.
  - `mac_weight` = {value=`rdata_b`, valid=`rd_v`}.
  - Bubbles present valid=0, so the MAC holds its accumulator.
- DRAIN: fixed 2 cycles using an internal counter; `stall` is ignored. On the final DRAIN cycle's edge, `result` <= `mac_out`.
- DONE: `done`=1 and `busy`=1 for one cycle, then IDLE.
- `abort`=1 in CLEAR, ISSUE or DRAIN:
  - Next state is IDLE.
  - `mac_clear`=1 in that next cycle.
  - No `done` pulse and `result` unchanged.
  - `abort` is ignored in IDLE and DONE.
- Simultaneous `abort` and the last issue: `abort` wins.
- `len`=0 runs CLEAR→DRAIN→DONE; `result` is 0.0, since the accumulator was just cleared.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `rd_en`=0, `rd_addr_a`=0, `rd_addr_b`=0, `mac_clear`=0, `mac_data`/`mac_weight` valid=0 and value=0.
- Internal reset state: FSM in IDLE, `idx`=0.
- An asserted `rst_n` mid-command aborts immediately; no `done` follows.
- Cycle map with no stalls, start accepted in cycle 0:
  - Cycle 1: CLEAR.
  - Cycles 2..N+1: ISSUE.
  - Cycles N+2, N+3: DRAIN.
  - Cycle N+4: DONE, `done`=1 with `result` valid.
- Each stalled cycle adds one cycle of latency.
- The next `start` is accepted at cycle N+5 at the earliest.
- Last issue in cycle T: operands reach the MAC in T+1; `mac_out` is final in T+2 and is captured at the end of T+2.
- `result` changes only on the DRAIN→DONE edge and stays stable through and after `done`.

## Test plan
- len=4, a=[1.0,2.0,3.0,4.0] at base_a=0, b=all 1.0 at base_b=0, stride 1:
  - `done` in cycle 8.
  - `result`=32'h41200000 (10.0).
  - `rd_en` high in cycles 2–5.
- len=3, base_b=8'h10, stride_b=3: `rd_addr_b` = 8'h10, 8'h13, 8'h16; base_a=8'hFE, len=4 gives `rd_addr_a` = FE, FF, 00, 01 (wrap).
- len=4 with `stall`=1 in cycles 3–4:
  - No `rd_en` in cycles 3–4.
  - `done` in cycle 10.
  - `result` identical to the no-stall run (10.0).
- len=0:
  - `mac_clear` in cycle 1.
  - `done` in cycle 4.
  - `result`=0.
  - `rd_en` never asserted.
- `abort` in cycle 4 of a len=8 run:
  - IDLE in cycle 5 with `mac_clear`=1.
  - No `done`; `result` keeps its prior value.
  - A `start` in cycle 5 runs normally.
- `rst_n` low in the middle of ISSUE: all outputs return to their reset values asynchronously and there is no `done`. `start` while `busy` is ignored: a single `done` per accepted command.

Source files
------------

// File: rtl/mm_dot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mm_dot_ctrl
//  Description : Sequencer for one MM MAC lane. Computes a single dot product
//                of length len by streaming operand pairs from two
//                single-port read buffers into the MAC. The accumulator is
//                cleared first and the MAC pipeline is drained afterwards.
//                The final accumulator value is captured into result, and
//                completion is signalled with a start/busy/done handshake.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n            clock, asynchronous active-low reset
//    start, abort          command request (IDLE only) / abort running command
//    len, base_a, base_b,
//    stride_b              command fields, latched when start is accepted
//    stall                 buffer back-pressure, suppresses issue while high
//    rd_en, rd_addr_a/b    shared read strobe and per-buffer read addresses
//    rdata_a/b             buffer read data, valid the cycle after rd_en
//    mac_clear             MAC accumulator clear
//    mac_data, mac_weight  MAC operands, packed {value[32:1], valid[0]}
//    mac_out               MAC accumulator (IEEE single)
//    busy, done, result    status, one-cycle completion pulse, dot product
// ============================================================================
module mm_dot_ctrl #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] stride_b,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [31:0]       rdata_a,
    input  logic [31:0]       rdata_b,
    output logic              mac_clear,
    output logic [32:0]       mac_data,
    output logic [32:0]       mac_weight,
    input  logic [31:0]       mac_out,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [LEN_W-1:0]  C_LEN_ZERO = '0;
    localparam logic [LEN_W-1:0]  C_LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_idx;
    logic [ADDR_W-1:0] r_addr_a;
    logic [ADDR_W-1:0] r_addr_b;
    logic [ADDR_W-1:0] r_stride_b;
    logic              r_drain_cnt;
    logic              r_rd_v;
    logic              r_abort_clr;
    logic [31:0]       r_result;

    logic              w_accept;
    logic              w_abort;
    logic              w_capture;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        w_capture   = 1'b0;
        rd_en       = 1'b0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        // An abort issues its accumulator clear in the cycle after it.
        mac_clear   = r_abort_clr;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                mac_clear = 1'b1;
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_len != C_LEN_ZERO) begin
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_ISSUE: begin
                // Abort takes priority over any issue, including the last,
                // so no operand reaches the MAC alongside the abort clear.
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (!stall) begin
                    rd_en = 1'b1;
                    if (r_idx == (r_len - C_LEN_ONE)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Two fixed cycles: last operands enter the MAC in the first,
                // mac_out is final in the second and captured at its end.
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_drain_cnt) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command registers, address generation, operand valid, result
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_addr_a    <= '0;
            r_addr_b    <= '0;
            r_stride_b  <= '0;
            r_drain_cnt <= 1'b0;
            r_rd_v      <= 1'b0;
            r_abort_clr <= 1'b0;
            r_result    <= '0;
        end else begin
            r_rd_v      <= rd_en;
            r_abort_clr <= w_abort;

            if (w_accept) begin
                r_len      <= len;
                r_idx      <= '0;
                r_addr_a   <= base_a;
                r_addr_b   <= base_b;
                r_stride_b <= stride_b;
            end else if (rd_en) begin
                // Running sums; addresses wrap modulo 2^ADDR_W.
                r_idx    <= r_idx + C_LEN_ONE;
                r_addr_a <= r_addr_a + C_ADDR_ONE;
                r_addr_b <= r_addr_b + r_stride_b;
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= ~r_drain_cnt;
            end else begin
                r_drain_cnt <= 1'b0;
            end

            if (w_capture) begin
                r_result <= mac_out;
            end
        end
    end

    assign rd_addr_a  = r_addr_a;
    assign rd_addr_b  = r_addr_b;
    // Bubbles present valid=0 and a zero value so the MAC holds.
    assign mac_data   = {(r_rd_v ? rdata_a : 32'h0), r_rd_v};
    assign mac_weight = {(r_rd_v ? rdata_b : 32'h0), r_rd_v};
    assign result     = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mm_dot_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mm_dot_ctrl
//  Description : Self-checking bench for mm_dot_ctrl with behavioural read
//                buffers, an integer-valued MAC model and a result scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mm_dot_ctrl;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic              stall    = 1'b0;
    logic [LEN_W-1:0]  len      = '0;
    logic [ADDR_W-1:0] base_a   = '0;
    logic [ADDR_W-1:0] base_b   = '0;
    logic [ADDR_W-1:0] stride_b = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [31:0]       rdata_a  = '0;
    logic [31:0]       rdata_b  = '0;
    logic              mac_clear;
    logic [32:0]       mac_data;
    logic [32:0]       mac_weight;
    logic [31:0]       mac_out;
    logic              busy;
    logic              done;
    logic [31:0]       result;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] sb_q [$];
    logic [31:0] sb_exp;
    int          acc = 0;

    logic        l_rd_en  [64];
    logic [7:0]  l_addr_a [64];
    logic [7:0]  l_addr_b [64];
    logic        l_done   [64];
    logic        l_clear  [64];
    logic        l_busy   [64];
    logic [31:0] l_result [64];
    int          n_done;
    logic        s_busy;
    logic        s_clear;
    logic [31:0] s_result;

    mm_dot_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .len        (len),
        .base_a     (base_a),
        .base_b     (base_b),
        .stride_b   (stride_b),
        .stall      (stall),
        .rd_en      (rd_en),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rdata_a    (rdata_a),
        .rdata_b    (rdata_b),
        .mac_clear  (mac_clear),
        .mac_data   (mac_data),
        .mac_weight (mac_weight),
        .mac_out    (mac_out),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // Integer-valued IEEE single helpers (magnitudes below 2^24).
    function automatic int fp2int(input logic [31:0] f);
        int e;
        int m;
        if (f[30:0] == 31'd0) return 0;
        e = int'(f[30:23]);
        m = int'({1'b1, f[22:0]});
        m = m >>> (150 - e);
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] int2fp(input int v);
        int          mag;
        int          p;
        logic [31:0] mm;
        logic [7:0]  ex;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? -v : v;
        p = 0;
        for (int i = 0; i < 31; i++) if (mag[i]) p = i;
        mm = 32'(mag) << (23 - p);
        ex = 8'(127 + p);
        return {(v < 0), ex, mm[22:0]};
    endfunction

    function automatic logic [31:0] ref_dot(input int n, input int ba, input int bb, input int sb);
        int s;
        s = 0;
        for (int i = 0; i < n; i++)
            s += fp2int(mem_a[8'(ba + i)]) * fp2int(mem_b[8'(bb + i * sb)]);
        return int2fp(s);
    endfunction

    // Read buffers: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) begin
            rdata_a <= mem_a[rd_addr_a];
            rdata_b <= mem_b[rd_addr_b];
        end
    end

    // MAC lane model: clear wins, otherwise accumulate valid pairs.
    always @(posedge clk) begin
        if (mac_clear) acc <= 0;
        else if (mac_data[0] && mac_weight[0])
            acc <= acc + fp2int(mac_data[32:1]) * fp2int(mac_weight[32:1]);
    end
    assign mac_out = int2fp(acc);

    // Scoreboard: every done pops one expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: result=%h, no command expected", result);
            end else begin
                sb_exp = sb_q.pop_front();
                if (result !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_result: got %h expected %h", result, sb_exp);
                end
            end
        end
    end

    // Called at posedge+1; start is presented for one cycle (cycle 0).
    task automatic start_cmd(input int n, input int ba, input int bb, input int sb);
        len      = LEN_W'(n);
        base_a   = 8'(ba);
        base_b   = 8'(bb);
        stride_b = 8'(sb);
        start    = 1'b1;
        @(negedge clk);
        s_busy   = busy;
        s_clear  = mac_clear;
        s_result = result;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Records cycles 1..ncyc after the start cycle, driving stall/abort/start.
    task automatic watch(input int ncyc, input int st_lo, input int st_hi,
                         input int ab_c, input int sr_lo, input int sr_hi);
        n_done = 0;
        for (int c = 0; c < 64; c++) begin
            l_rd_en[c] = 1'b0; l_addr_a[c] = '0; l_addr_b[c] = '0; l_done[c] = 1'b0;
            l_clear[c] = 1'b0; l_busy[c] = 1'b0; l_result[c] = '0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            stall = (c >= st_lo && c <= st_hi);
            abort = (c == ab_c);
            start = (c >= sr_lo && c <= sr_hi);
            @(negedge clk);
            l_rd_en[c]  = rd_en;
            l_addr_a[c] = rd_addr_a;
            l_addr_b[c] = rd_addr_b;
            l_done[c]   = done;
            l_clear[c]  = mac_clear;
            l_busy[c]   = busy;
            l_result[c] = result;
            if (done) n_done++;
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_result: got %h expected 0", result); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_addr_a !== 8'h0 || rd_addr_b !== 8'h0) begin errors++; $display("FAIL rst_addr: got %h/%h expected 0/0", rd_addr_a, rd_addr_b); end
        checks++; if (mac_clear !== 1'b0) begin errors++; $display("FAIL rst_mac_clear: got %b expected 0", mac_clear); end
        checks++; if (mac_data !== 33'h0 || mac_weight !== 33'h0) begin errors++; $display("FAIL rst_mac_ops: got %h/%h expected 0/0", mac_data, mac_weight); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic e;
        sb_q.push_back(ref_dot(4, 0, 0, 1));
        start_cmd(4, 0, 0, 1);
        watch(10, -1, -1, -1, -1, -1);
        checks++; if (l_done[8] !== 1'b1 || n_done != 1) begin errors++; $display("FAIL basic_done_cycle: done@8=%b count=%0d expected 1/1", l_done[8], n_done); end
        checks++; if (l_result[8] !== 32'h41200000) begin errors++; $display("FAIL basic_result: got %h expected 41200000", l_result[8]); end
        for (int c = 1; c <= 10; c++) begin
            e = (c >= 2 && c <= 5);
            checks++; if (l_rd_en[c] !== e) begin errors++; $display("FAIL basic_rd_en c%0d: got %b expected %b", c, l_rd_en[c], e); end
        end
        checks++; if (l_clear[1] !== 1'b1 || l_clear[2] !== 1'b0) begin errors++; $display("FAIL basic_clear: got %b%b expected 10", l_clear[1], l_clear[2]); end
        checks++; if (l_busy[8] !== 1'b1 || l_busy[9] !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b%b expected 10", l_busy[8], l_busy[9]); end
    endtask

    task automatic test_len0();
        sb_q.push_back(ref_dot(0, 0, 0, 1));
        start_cmd(0, 0, 0, 1);
        watch(6, -1, -1, -1, -1, -1);
        checks++; if (l_clear[1] !== 1'b1) begin errors++; $display("FAIL len0_clear: got %b expected 1", l_clear[1]); end
        checks++; if (l_done[4] !== 1'b1 || n_done != 1) begin errors++; $display("FAIL len0_done_cycle: done@4=%b count=%0d expected 1/1", l_done[4], n_done); end
        checks++; if (l_result[4] !== 32'h0) begin errors++; $display("FAIL len0_result: got %h expected 0", l_result[4]); end
        for (int c = 1; c <= 6; c++) begin
            checks++; if (l_rd_en[c] !== 1'b0) begin errors++; $display("FAIL len0_rd_en c%0d: got %b expected 0", c, l_rd_en[c]); end
        end
    endtask

    task automatic test_addr();
        logic [7:0] ea;
        sb_q.push_back(ref_dot(3, 8'h40, 8'h10, 3));
        start_cmd(3, 8'h40, 8'h10, 3);
        watch(8, -1, -1, -1, -1, -1);
        for (int c = 2; c <= 4; c++) begin
            ea = 8'(8'h10 + 3 * (c - 2));
            checks++; if (l_rd_en[c] !== 1'b1 || l_addr_b[c] !== ea) begin errors++; $display("FAIL addr_b c%0d: got en=%b %h expected en=1 %h", c, l_rd_en[c], l_addr_b[c], ea); end
        end
        sb_q.push_back(ref_dot(4, 8'hFE, 8'h20, 2));
        start_cmd(4, 8'hFE, 8'h20, 2);
        watch(9, -1, -1, -1, -1, -1);
        for (int c = 2; c <= 5; c++) begin
            ea = 8'(8'hFE + (c - 2));
            checks++; if (l_rd_en[c] !== 1'b1 || l_addr_a[c] !== ea) begin errors++; $display("FAIL addr_a_wrap c%0d: got en=%b %h expected en=1 %h", c, l_rd_en[c], l_addr_a[c], ea); end
            ea = 8'(8'h20 + 2 * (c - 2));
            checks++; if (l_addr_b[c] !== ea) begin errors++; $display("FAIL addr_b2 c%0d: got %h expected %h", c, l_addr_b[c], ea); end
        end
    endtask

    task automatic test_stall();
        logic e;
        sb_q.push_back(ref_dot(4, 0, 0, 1));
        start_cmd(4, 0, 0, 1);
        watch(12, 3, 4, -1, -1, -1);
        for (int c = 1; c <= 12; c++) begin
            e = (c == 2 || (c >= 5 && c <= 7));
            checks++; if (l_rd_en[c] !== e) begin errors++; $display("FAIL stall_rd_en c%0d: got %b expected %b", c, l_rd_en[c], e); end
        end
        checks++; if (l_done[10] !== 1'b1 || n_done != 1) begin errors++; $display("FAIL stall_done_cycle: done@10=%b count=%0d expected 1/1", l_done[10], n_done); end
        checks++; if (l_result[10] !== 32'h41200000) begin errors++; $display("FAIL stall_result: got %h expected 41200000", l_result[10]); end
    endtask

    task automatic test_abort();
        start_cmd(8, 0, 0, 1);
        watch(4, -1, -1, 4, -1, -1);
        checks++; if (n_done != 0 || l_busy[4] !== 1'b1) begin errors++; $display("FAIL abort_run: got done=%0d busy@4=%b expected 0/1", n_done, l_busy[4]); end
        sb_q.push_back(ref_dot(2, 3, 5, 1));
        start_cmd(2, 3, 5, 1);
        checks++; if (s_busy !== 1'b0 || s_clear !== 1'b1) begin errors++; $display("FAIL abort_idle_clear: got busy=%b clear=%b expected 0/1", s_busy, s_clear); end
        checks++; if (s_result !== 32'h41200000) begin errors++; $display("FAIL abort_result_kept: got %h expected 41200000", s_result); end
        watch(8, -1, -1, -1, -1, -1);
        checks++; if (l_done[6] !== 1'b1 || n_done != 1) begin errors++; $display("FAIL abort_restart_done: done@6=%b count=%0d expected 1/1", l_done[6], n_done); end
    endtask

    task automatic test_reset_mid();
        int nb;
        start_cmd(8, 0, 0, 1);
        watch(3, -1, -1, -1, -1, -1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: got busy=%b rd_en=%b done=%b expected 000", busy, rd_en, done); end
        checks++; if (rd_addr_a !== 8'h0 || rd_addr_b !== 8'h0) begin errors++; $display("FAIL midrst_addr: got %h/%h expected 0/0", rd_addr_a, rd_addr_b); end
        checks++; if (result !== 32'h0 || mac_clear !== 1'b0 || mac_data !== 33'h0) begin errors++; $display("FAIL midrst_data: got result=%h clear=%b data=%h expected 0", result, mac_clear, mac_data); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        watch(14, -1, -1, -1, -1, -1);
        nb = 0;
        for (int c = 1; c <= 14; c++) if (l_busy[c]) nb++;
        checks++; if (n_done != 0 || nb != 0) begin errors++; $display("FAIL midrst_after: got done=%0d busy_cycles=%0d expected 0/0", n_done, nb); end
    endtask

    task automatic test_back_to_back();
        sb_q.push_back(ref_dot(2, 0, 0, 1));
        start_cmd(2, 0, 0, 1);
        len = LEN_W'(7);
        watch(6, -1, -1, -1, 2, 4);
        checks++; if (l_done[6] !== 1'b1 || n_done != 1) begin errors++; $display("FAIL b2b_first_done: done@6=%b count=%0d expected 1/1", l_done[6], n_done); end
        sb_q.push_back(ref_dot(3, 1, 2, 2));
        start_cmd(3, 1, 2, 2);
        checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_at_n5: got busy=%b expected 0", s_busy); end
        watch(9, -1, -1, -1, -1, -1);
        checks++; if (l_done[7] !== 1'b1 || n_done != 1) begin errors++; $display("FAIL b2b_second_done: done@7=%b count=%0d expected 1/1", l_done[7], n_done); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = int2fp((i % 5) + 1);
            mem_b[i] = (i < 8) ? int2fp(1) : int2fp((i % 4) + 1);
        end
        test_reset();
        test_basic();
        test_len0();
        test_addr();
        test_stall();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
